// File: rtl/ex_hazard_scoreboard_pkg.sv
// Shared widths, limits and branch-FSM encodings for the Execute-stage hazard scoreboard.
// Also provides the clamp used by the in-flight write accumulator.
package ex_hazard_scoreboard_pkg;

    localparam int NUM_SREG        = 16;
    localparam int SREG_ID_WIDTH   = 4;
    localparam int VREG_ID_WIDTH   = 6;
    localparam int NUM_VREG        = 1 << VREG_ID_WIDTH;
    localparam int SB_CNT_WIDTH    = 2;
    localparam int SB_MAX_INFLIGHT = 3;
    localparam int INFLIGHT_WIDTH  = 4;

    typedef enum logic [1:0] {
        SB_IDLE    = 2'd0,
        SB_BR_WAIT = 2'd1,
        SB_FLUSH   = 2'd2
    } sb_state_e;

    // The accumulator clamps to [0, 15] rather than wrapping.
    function automatic logic [INFLIGHT_WIDTH-1:0] sat_inflight(
        input logic [INFLIGHT_WIDTH-1:0] cur,
        input logic [1:0]                up,
        input logic [1:0]                dn
    );
        logic signed [6:0] sum;
        sum = $signed({3'b000, cur}) + $signed({5'b00000, up}) - $signed({5'b00000, dn});
        if (sum < 0)
            return '0;
        else if (sum > 7'sd15)
            return '1;
        else
            return sum[INFLIGHT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// N saturating up/down counters of outstanding writes, one increment and one decrement port.
// Reports per-entry nonzero/full plus whether a net increment or decrement actually took effect.
module sb_counter_bank
    import ex_hazard_scoreboard_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic             dec_en,
    input  logic [IDX_W-1:0] dec_idx,
    output logic [N-1:0]     nonzero,
    output logic [N-1:0]     full,
    output logic             up,
    output logic             down
);

    logic [SB_CNT_WIDTH-1:0] cnt_q [N];
    logic [SB_CNT_WIDTH-1:0] cnt_d [N];
    logic [N-1:0]            up_vec;
    logic [N-1:0]            down_vec;
    logic [N-1:0]            under_vec;
    logic                    inc_hit;
    logic                    dec_hit;

    // An issue and a retire hitting the same entry cancel out.
    always_comb begin
        inc_hit = 1'b0;
        dec_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            inc_hit      = inc_en && (inc_idx == IDX_W'(i));
            dec_hit      = dec_en && (dec_idx == IDX_W'(i));
            cnt_d[i]     = cnt_q[i];
            up_vec[i]    = 1'b0;
            down_vec[i]  = 1'b0;
            under_vec[i] = 1'b0;
            if (inc_hit && !dec_hit && (cnt_q[i] != SB_CNT_WIDTH'(SB_MAX_INFLIGHT))) begin
                cnt_d[i]  = cnt_q[i] + 1'b1;
                up_vec[i] = 1'b1;
            end
            if (dec_hit && !inc_hit) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i]    = cnt_q[i] - 1'b1;
                    down_vec[i] = 1'b1;
                end else begin
                    under_vec[i] = 1'b1;
                end
            end
            nonzero[i] = (cnt_q[i] != '0);
            full[i]    = (cnt_q[i] == SB_CNT_WIDTH'(SB_MAX_INFLIGHT));
        end
    end

    assign up   = |up_vec;
    assign down = |down_vec;

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    underflow_a: assert property (@(negedge clk) disable iff (!rst_n) !(|under_vec));

endmodule

// File: rtl/ex_hazard_scoreboard.sv
// Execute-stage issue controller: RAW/WAW stalls from outstanding-write counters,
// a branch-resolve FSM that holds Fetch and flushes Decode, and an in-flight write count.
module ex_hazard_scoreboard
    import ex_hazard_scoreboard_pkg::*;
(
    input  logic                      I_CLOCK,
    input  logic                      I_RESET_N,
    input  logic                      I_GPUStallSignal,
    input  logic                      I_Issue_Valid,
    input  logic                      I_Issue_RegWEn,
    input  logic [SREG_ID_WIDTH-1:0]  I_Issue_DestRegIdx,
    input  logic                      I_Issue_VRegWEn,
    input  logic [VREG_ID_WIDTH-1:0]  I_Issue_DestVRegIdx,
    input  logic                      I_Issue_CCWEn,
    input  logic                      I_Issue_IsBranch,
    input  logic [SREG_ID_WIDTH-1:0]  I_Src1RegIdx,
    input  logic [SREG_ID_WIDTH-1:0]  I_Src2RegIdx,
    input  logic                      I_Src1Used,
    input  logic                      I_Src2Used,
    input  logic [VREG_ID_WIDTH-1:0]  I_VSrc1RegIdx,
    input  logic [VREG_ID_WIDTH-1:0]  I_VSrc2RegIdx,
    input  logic                      I_VSrcUsed,
    input  logic                      I_CCRead,
    input  logic [SREG_ID_WIDTH-1:0]  I_DestRegIdx_Q,
    input  logic [VREG_ID_WIDTH-1:0]  I_DestVRegIdx_Q,
    input  logic                      I_WB_Valid,
    input  logic                      I_WB_RegWEn,
    input  logic                      I_WB_VRegWEn,
    input  logic                      I_WB_CCWEn,
    input  logic [SREG_ID_WIDTH-1:0]  I_WB_DestRegIdx,
    input  logic [VREG_ID_WIDTH-1:0]  I_WB_DestVRegIdx,
    input  logic                      I_BranchResolved,
    input  logic                      I_BranchTaken,
    output logic                      O_DE_Stall,
    output logic                      O_FE_Stall,
    output logic                      O_FlushDE,
    output logic [INFLIGHT_WIDTH-1:0] O_InFlight
);

    logic [NUM_SREG-1:0]       s_nonzero, s_full;
    logic [NUM_VREG-1:0]       v_nonzero, v_full;
    logic                      cc_nonzero, cc_full;
    logic                      s_up, s_down, v_up, v_down, cc_up, cc_down;
    logic                      accept, hazard, cc_inc, cc_dec;
    logic [1:0]                up_cnt, dn_cnt;
    sb_state_e                 state_q, state_d;
    logic [INFLIGHT_WIDTH-1:0] inflight_q, inflight_d;

    assign accept = I_Issue_Valid & ~O_DE_Stall;
    assign cc_inc = accept & I_Issue_CCWEn;
    assign cc_dec = I_WB_Valid & I_WB_CCWEn;

    sb_counter_bank #(.N(NUM_SREG)) u_sreg_bank (
        .clk     (I_CLOCK),
        .rst_n   (I_RESET_N),
        .inc_en  (accept & I_Issue_RegWEn),
        .inc_idx (I_Issue_DestRegIdx),
        .dec_en  (I_WB_Valid & I_WB_RegWEn),
        .dec_idx (I_WB_DestRegIdx),
        .nonzero (s_nonzero),
        .full    (s_full),
        .up      (s_up),
        .down    (s_down)
    );

    sb_counter_bank #(.N(NUM_VREG)) u_vreg_bank (
        .clk     (I_CLOCK),
        .rst_n   (I_RESET_N),
        .inc_en  (accept & I_Issue_VRegWEn),
        .inc_idx (I_Issue_DestVRegIdx),
        .dec_en  (I_WB_Valid & I_WB_VRegWEn),
        .dec_idx (I_WB_DestVRegIdx),
        .nonzero (v_nonzero),
        .full    (v_full),
        .up      (v_up),
        .down    (v_down)
    );

    sb_counter_bank #(.N(1)) u_cc_bank (
        .clk     (I_CLOCK),
        .rst_n   (I_RESET_N),
        .inc_en  (cc_inc),
        .inc_idx (1'b0),
        .dec_en  (cc_dec),
        .dec_idx (1'b0),
        .nonzero (cc_nonzero),
        .full    (cc_full),
        .up      (cc_up),
        .down    (cc_down)
    );

    // Registered counters only: a retire in this same cycle does not clear the hazard.
    always_comb begin
        hazard = 1'b0;
        if (I_Src1Used && s_nonzero[I_Src1RegIdx]) hazard = 1'b1;
        if (I_Src2Used && s_nonzero[I_Src2RegIdx]) hazard = 1'b1;
        if (I_VSrcUsed && (v_nonzero[I_VSrc1RegIdx] || v_nonzero[I_VSrc2RegIdx])) hazard = 1'b1;
        if (I_CCRead && cc_nonzero) hazard = 1'b1;
        if (s_full[I_DestRegIdx_Q] || v_full[I_DestVRegIdx_Q]) hazard = 1'b1;
    end

    assign O_DE_Stall = hazard | I_GPUStallSignal | (state_q != SB_IDLE) | ~I_RESET_N;
    assign O_FE_Stall = O_DE_Stall | (state_q == SB_BR_WAIT);
    assign O_FlushDE  = (state_q == SB_FLUSH);
    assign O_InFlight = inflight_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE:    if (accept && I_Issue_IsBranch) state_d = SB_BR_WAIT;
            SB_BR_WAIT: if (I_BranchResolved) state_d = I_BranchTaken ? SB_FLUSH : SB_IDLE;
            SB_FLUSH:   state_d = SB_IDLE;
            default:    state_d = SB_IDLE;
        endcase
    end

    always_comb begin
        up_cnt     = 2'(s_up) + 2'(v_up) + 2'(cc_up);
        dn_cnt     = 2'(s_down) + 2'(v_down) + 2'(cc_down);
        inflight_d = sat_inflight(inflight_q, up_cnt, dn_cnt);
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_RESET_N) begin
            state_q    <= SB_IDLE;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    issue_while_stalled_a: assert property (@(negedge I_CLOCK) disable iff (!I_RESET_N)
        !(I_Issue_Valid && O_DE_Stall));
    cc_overflow_a: assert property (@(negedge I_CLOCK) disable iff (!I_RESET_N)
        !(cc_inc && cc_full && !cc_dec));

endmodule

// File: tb/tb_ex_hazard_scoreboard.sv
// Directed bench for ex_hazard_scoreboard: RAW/WAW stalls, same-cycle issue/retire,
// CC-dependent branch with taken/not-taken resolve, GPU back-pressure and mid-branch reset.
module tb_ex_hazard_scoreboard;
    import ex_hazard_scoreboard_pkg::*;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic                      gpu_stall;
    logic                      issue_valid, issue_reg_wen, issue_vreg_wen, issue_cc_wen, issue_is_branch;
    logic [SREG_ID_WIDTH-1:0]  issue_dest, src1, src2, dest_q, wb_dest;
    logic [VREG_ID_WIDTH-1:0]  issue_vdest, vsrc1, vsrc2, vdest_q, wb_vdest;
    logic                      src1_used, src2_used, vsrc_used, cc_read;
    logic                      wb_valid, wb_reg_wen, wb_vreg_wen, wb_cc_wen;
    logic                      br_resolved, br_taken;
    logic                      de_stall, fe_stall, flush_de;
    logic [INFLIGHT_WIDTH-1:0] in_flight;
    int                        checks_total  = 0;
    int                        checks_passed = 0;

    always #5 clock = ~clock;

    ex_hazard_scoreboard dut (
        .I_CLOCK             (clock),
        .I_RESET_N           (reset_n),
        .I_GPUStallSignal    (gpu_stall),
        .I_Issue_Valid       (issue_valid),
        .I_Issue_RegWEn      (issue_reg_wen),
        .I_Issue_DestRegIdx  (issue_dest),
        .I_Issue_VRegWEn     (issue_vreg_wen),
        .I_Issue_DestVRegIdx (issue_vdest),
        .I_Issue_CCWEn       (issue_cc_wen),
        .I_Issue_IsBranch    (issue_is_branch),
        .I_Src1RegIdx        (src1),
        .I_Src2RegIdx        (src2),
        .I_Src1Used          (src1_used),
        .I_Src2Used          (src2_used),
        .I_VSrc1RegIdx       (vsrc1),
        .I_VSrc2RegIdx       (vsrc2),
        .I_VSrcUsed          (vsrc_used),
        .I_CCRead            (cc_read),
        .I_DestRegIdx_Q      (dest_q),
        .I_DestVRegIdx_Q     (vdest_q),
        .I_WB_Valid          (wb_valid),
        .I_WB_RegWEn         (wb_reg_wen),
        .I_WB_VRegWEn        (wb_vreg_wen),
        .I_WB_CCWEn          (wb_cc_wen),
        .I_WB_DestRegIdx     (wb_dest),
        .I_WB_DestVRegIdx    (wb_vdest),
        .I_BranchResolved    (br_resolved),
        .I_BranchTaken       (br_taken),
        .O_DE_Stall          (de_stall),
        .O_FE_Stall          (fe_stall),
        .O_FlushDE           (flush_de),
        .O_InFlight          (in_flight)
    );

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks_total++;
        if (actual === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // State advances on the falling edge; inputs change and outputs are sampled 1ns after it.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clock);
        #1;
    endtask

    task automatic clearInputs();
        gpu_stall = 0; issue_valid = 0; issue_reg_wen = 0; issue_vreg_wen = 0;
        issue_cc_wen = 0; issue_is_branch = 0; issue_dest = 0; issue_vdest = 0;
        src1 = 0; src2 = 0; src1_used = 0; src2_used = 0; vsrc1 = 0; vsrc2 = 0;
        vsrc_used = 0; cc_read = 0; dest_q = 0; vdest_q = 0; wb_valid = 0;
        wb_reg_wen = 0; wb_vreg_wen = 0; wb_cc_wen = 0; wb_dest = 0; wb_vdest = 0;
        br_resolved = 0; br_taken = 0;
    endtask

    task automatic issueScalar(input logic [SREG_ID_WIDTH-1:0] d);
        issue_valid = 1; issue_reg_wen = 1; issue_dest = d;
    endtask

    task automatic retireScalar(input logic [SREG_ID_WIDTH-1:0] d);
        wb_valid = 1; wb_reg_wen = 1; wb_dest = d;
    endtask

    initial begin
        clearInputs();
        reset_n = 0;
        #2;
        checkOutput("rst_de_stall", de_stall, 1);
        checkOutput("rst_fe_stall", fe_stall, 1);
        applyStimulus(2);
        checkOutput("rst_inflight", in_flight, 0);
        checkOutput("rst_flush", flush_de, 0);
        reset_n = 1; #1;
        checkOutput("rel_de_stall", de_stall, 0);
        checkOutput("rel_fe_stall", fe_stall, 0);

        // RAW on R2 until its retire has been registered
        issueScalar(2); #1;
        checkOutput("t1_accept", de_stall, 0);
        applyStimulus(1); clearInputs();
        src1_used = 1; src1 = 2; #1;
        checkOutput("t1_raw_stall", de_stall, 1);
        checkOutput("t1_inflight", in_flight, 1);
        applyStimulus(1);
        checkOutput("t1_raw_hold", de_stall, 1);
        retireScalar(2); #1;
        checkOutput("t1_no_bypass", de_stall, 1);
        applyStimulus(1); wb_valid = 0; wb_reg_wen = 0; #1;
        checkOutput("t1_after_retire", de_stall, 0);
        checkOutput("t1_inflight_0", in_flight, 0);

        // WAW: three writes to R5 fill its counter
        clearInputs();
        for (int i = 0; i < 3; i++) begin
            issueScalar(5); #1;
            checkOutput("t2_accept", de_stall, 0);
            applyStimulus(1); clearInputs();
        end
        dest_q = 5; #1;
        checkOutput("t2_waw_full", de_stall, 1);
        checkOutput("t2_inflight_3", in_flight, 3);
        retireScalar(5); #1;
        checkOutput("t2_retire_cycle", de_stall, 1);
        applyStimulus(1); wb_valid = 0; wb_reg_wen = 0; #1;
        checkOutput("t2_after_retire", de_stall, 0);
        checkOutput("t2_inflight_2", in_flight, 2);
        retireScalar(5);
        applyStimulus(2); clearInputs(); #1;
        checkOutput("t2_inflight_0", in_flight, 0);

        // Same-cycle accept and retire of R4 leaves its counter at 1
        issueScalar(4);
        applyStimulus(1); clearInputs();
        issueScalar(4); retireScalar(4); #1;
        checkOutput("t3_accept", de_stall, 0);
        applyStimulus(1); clearInputs(); #1;
        checkOutput("t3_inflight_1", in_flight, 1);
        src1_used = 1; src1 = 4; #1;
        checkOutput("t3_still_busy", de_stall, 1);
        retireScalar(4);
        applyStimulus(1); clearInputs(); #1;
        checkOutput("t3_cleared", de_stall, 0);
        checkOutput("t3_inflight_0", in_flight, 0);

        // CMPI then BRZ, resolved taken
        issue_valid = 1; issue_cc_wen = 1;
        applyStimulus(1); clearInputs();
        cc_read = 1; #1;
        checkOutput("t4_cc_stall", de_stall, 1);
        checkOutput("t4_inflight_1", in_flight, 1);
        wb_valid = 1; wb_cc_wen = 1; #1;
        checkOutput("t4_cc_no_bypass", de_stall, 1);
        applyStimulus(1); wb_valid = 0; wb_cc_wen = 0; #1;
        checkOutput("t4_cc_free", de_stall, 0);
        issue_valid = 1; issue_is_branch = 1; #1;
        checkOutput("t4_br_accept", de_stall, 0);
        applyStimulus(1); clearInputs(); #1;
        checkOutput("t4_brwait_de", de_stall, 1);
        checkOutput("t4_brwait_fe", fe_stall, 1);
        checkOutput("t4_brwait_flush", flush_de, 0);
        applyStimulus(1);
        checkOutput("t4_brwait_hold", fe_stall, 1);
        br_resolved = 1; br_taken = 1;
        applyStimulus(1); clearInputs(); #1;
        checkOutput("t4_flush", flush_de, 1);
        checkOutput("t4_flush_de", de_stall, 1);
        applyStimulus(1);
        checkOutput("t4_flush_1cyc", flush_de, 0);
        checkOutput("t4_idle_de", de_stall, 0);
        checkOutput("t4_idle_fe", fe_stall, 0);

        // Not-taken branch, resolve in IDLE, then GPU back-pressure
        issue_valid = 1; issue_is_branch = 1;
        applyStimulus(1); clearInputs();
        br_resolved = 1; br_taken = 0; #1;
        checkOutput("t5_nt_fe", fe_stall, 1);
        applyStimulus(1); clearInputs(); #1;
        checkOutput("t5_nt_flush", flush_de, 0);
        checkOutput("t5_nt_idle", de_stall, 0);
        br_resolved = 1; br_taken = 1;
        applyStimulus(1); clearInputs(); #1;
        checkOutput("t5_idle_resolve", flush_de, 0);
        checkOutput("t5_idle_resolve_de", de_stall, 0);
        issueScalar(3);
        applyStimulus(1); clearInputs();
        gpu_stall = 1; retireScalar(3); #1;
        checkOutput("t5_gpu_de", de_stall, 1);
        checkOutput("t5_gpu_fe", fe_stall, 1);
        checkOutput("t5_gpu_inflight_1", in_flight, 1);
        applyStimulus(1); wb_valid = 0; wb_reg_wen = 0; #1;
        checkOutput("t5_gpu_retire", in_flight, 0);
        checkOutput("t5_gpu_hold", de_stall, 1);
        gpu_stall = 0; #1;
        checkOutput("t5_gpu_release", de_stall, 0);

        // Three writes (scalar, vector, JSR to R7) plus BR_WAIT, then reset
        issueScalar(1);
        applyStimulus(1); clearInputs();
        issue_valid = 1; issue_vreg_wen = 1; issue_vdest = 10;
        applyStimulus(1); clearInputs();
        vsrc_used = 1; vsrc2 = 10; #1;
        checkOutput("t6_vec_raw", de_stall, 1);
        vsrc_used = 0; issueScalar(7); issue_is_branch = 1; #1;
        checkOutput("t6_jsr_accept", de_stall, 0);
        applyStimulus(1); clearInputs(); #1;
        checkOutput("t6_inflight_3", in_flight, 3);
        checkOutput("t6_brwait_fe", fe_stall, 1);
        reset_n = 0; #1;
        checkOutput("t6_rst_de", de_stall, 1);
        applyStimulus(1);
        reset_n = 1; #1;
        checkOutput("t6_inflight_0", in_flight, 0);
        checkOutput("t6_flush", flush_de, 0);
        checkOutput("t6_de_free", de_stall, 0);
        checkOutput("t6_fe_free", fe_stall, 0);
        src1_used = 1; src1 = 1; vsrc_used = 1; vsrc1 = 10; cc_read = 1; #1;
        checkOutput("t6_counters_clear", de_stall, 0);
        clearInputs();
        applyStimulus(1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
